// File: rtl/cnt_timer_sched.sv
// Round-robin scheduler that time-shares one external loadable up-counter as a one-shot delay timer.
// Define CNT_SCHED_ABORT_EN to add a per-requester ABORT input that cancels the active job.
module cnt_timer_sched #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] DLY,
`ifdef CNT_SCHED_ABORT_EN
  input  logic [NREQ-1:0]   ABORT,
`endif
  output logic [NREQ-1:0]   ACK,
  output logic [NREQ-1:0]   DONE,
  output logic              BUSY,
  output logic [IDW-1:0]    CUR_ID,
  output logic              CNT_EN,
  output logic              CNT_LOAD,
  output logic [W-1:0]      CNT_DATA,
  input  logic              CNT_COUT,
  input  logic [W-1:0]      CNT_DOUT
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic            dlyZero_q;
  logic [W-1:0]    data_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;

  logic [IDW-1:0]  win_d;
  logic            anyReq_d;
  logic            abortHit;
  logic            loadEn;
  logic [W-1:0]    dlyArr [NREQ];
  logic            unusedDout;

  // The counter value is exposed for debug only; control relies on CNT_COUT alone.
  assign unusedDout = ^CNT_DOUT;

  for (genvar g = 0; g < NREQ; g++) begin : gSlice
    assign dlyArr[g] = DLY[g*W +: W];
  end

  // Scan from the highest offset down so the nearest requester at or after the pointer wins last.
  always_comb begin
    logic [IDW-1:0] idx;
    idx      = '0;
    win_d    = '0;
    anyReq_d = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (REQ[idx]) begin
        win_d    = idx;
        anyReq_d = 1'b1;
      end
    end
  end

`ifdef CNT_SCHED_ABORT_EN
  assign abortHit = ABORT[id_q] && ((state_q == LOAD) || (state_q == RUN));
`else
  assign abortHit = 1'b0;
`endif

  // RUN gates the enable with COUT so the counter parks at all-ones instead of wrapping.
  assign loadEn   = (state_q == LOAD) && !dlyZero_q && !abortHit;
  assign CNT_EN   = loadEn || ((state_q == RUN) && !CNT_COUT && !abortHit);
  assign CNT_LOAD = !loadEn;
  assign CNT_DATA = data_q;
  assign ACK      = ack_q;
  assign DONE     = done_q;
  assign BUSY     = busy_q;
  assign CUR_ID   = id_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      dlyZero_q <= 1'b0;
      data_q    <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            state_q   <= LOAD;
            id_q      <= win_d;
            dlyZero_q <= (dlyArr[win_d] == '0);
            data_q    <= -dlyArr[win_d];
            ptr_q     <= IDW'((int'(win_d) + 1) % NREQ);
            ack_q     <= NREQ'(1) << win_d;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          ack_q  <= '0;
          data_q <= '0;
          if (abortHit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            id_q    <= '0;
          end else if (dlyZero_q) begin
            state_q <= FIN;
            done_q  <= NREQ'(1) << id_q;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abortHit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            id_q    <= '0;
          end else if (CNT_COUT) begin
            state_q <= FIN;
            done_q  <= NREQ'(1) << id_q;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= '0;
          busy_q  <= 1'b0;
          id_q    <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_timer_sched.sv
// Randomized scoreboard bench for cnt_timer_sched, driving a behavioural model of the shared counter.
`timescale 1ns/1ps
module tb_cnt_timer_sched;
  localparam int W    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NREQ-1:0]   REQ = '0;
  logic [NREQ*W-1:0] DLY = '0;
  logic [NREQ-1:0]   ACK;
  logic [NREQ-1:0]   DONE;
  logic              BUSY;
  logic [IDW-1:0]    CUR_ID;
  logic              CNT_EN;
  logic              CNT_LOAD;
  logic [W-1:0]      CNT_DATA;
  logic              CNT_COUT;
  logic [W-1:0]      cntQ = '0;
`ifdef CNT_SCHED_ABORT_EN
  logic [NREQ-1:0]   ABORT = '0;
`endif

  typedef struct {
    bit isDone;
    int id;
    int cyc;
    int dly;
  } ev_t;

  ev_t sb[$];
  ev_t ev;
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;
  int  modelPtr   = 0;
  int  dlyModel[NREQ];

  cnt_timer_sched #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .DLY      (DLY),
`ifdef CNT_SCHED_ABORT_EN
    .ABORT    (ABORT),
`endif
    .ACK      (ACK),
    .DONE     (DONE),
    .BUSY     (BUSY),
    .CUR_ID   (CUR_ID),
    .CNT_EN   (CNT_EN),
    .CNT_LOAD (CNT_LOAD),
    .CNT_DATA (CNT_DATA),
    .CNT_COUT (CNT_COUT),
    .CNT_DOUT (cntQ)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // The shared counter itself: enable-gated, active-low synchronous load, carry at all-ones.
  always @(posedge CLK) if (CNT_EN) cntQ <= !CNT_LOAD ? CNT_DATA : cntQ + 1'b1;
  assign CNT_COUT = (cntQ == '1);

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rrPick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int randD();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 255));
    return int'($urandom_range(0, 12));
  endfunction

  task automatic setDly(input int id, input int v);
    dlyModel[id] = v;
    DLY[id*W +: W] = W'(v);
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: every ACK/DONE pulse pops the next expected event.
  always @(negedge CLK) begin
    if (RST && (ACK != '0 || DONE != '0)) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_ack", int'(ACK), 0);
        checkOutput("spurious_done", int'(DONE), 0);
      end else begin
        ev = sb.pop_front();
        checkOutput(ev.isDone ? "done_vec" : "ack_vec", int'(ev.isDone ? DONE : ACK), 1 << ev.id);
        checkOutput(ev.isDone ? "ack_during_done" : "done_during_ack", int'(ev.isDone ? ACK : DONE), 0);
        checkOutput(ev.isDone ? "done_cycle" : "ack_cycle", cyc, ev.cyc);
        checkOutput("busy", int'(BUSY), 1);
        checkOutput("cur_id", int'(CUR_ID), ev.id);
        if (!ev.isDone) begin
          checkOutput("ack_data", int'(CNT_DATA), (256 - ev.dly) % 256);
          checkOutput("ack_load", int'(CNT_LOAD), (ev.dly != 0) ? 0 : 1);
          checkOutput("ack_en", int'(CNT_EN), (ev.dly != 0) ? 1 : 0);
        end else begin
          checkOutput("fin_en", int'(CNT_EN), 0);
          if (ev.dly != 0) checkOutput("fin_dout", int'(cntQ), 255);
        end
      end
    end
  end

  // One batch: raise mask, predict every grant by round-robin, drop/keep bits as requesters would.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] hold,
                               input int maxGrants, input bit scramble);
    int gId[$];
    int gAck[$];
    int gDly[$];
    logic [NREQ-1:0] gMask[$];
    logic [NREQ-1:0] cur;
    int t, w, d, doneCyc, lastDone;
    cur      = mask;
    REQ      = mask;
    t        = cyc + 1;
    lastDone = cyc;
    for (int g = 0; g < maxGrants && cur != '0; g++) begin
      w        = rrPick(cur, modelPtr);
      modelPtr = (w + 1) % NREQ;
      d        = dlyModel[w];
      doneCyc  = (d == 0) ? t + 1 : t + d + 1;
      sb.push_back('{isDone: 1'b0, id: w, cyc: t, dly: d});
      sb.push_back('{isDone: 1'b1, id: w, cyc: doneCyc, dly: d});
      if (!hold[w]) cur[w] = 1'b0;
      gId.push_back(w);
      gAck.push_back(t);
      gMask.push_back(cur);
      dlyModel[w] = scramble ? randD() : d;
      gDly.push_back(dlyModel[w]);
      lastDone = doneCyc;
      t        = doneCyc + 2;
    end
    for (int g = 0; g < gId.size(); g++) begin
      waitUntil(gAck[g]);
      REQ = (g == gId.size() - 1) ? '0 : gMask[g];
      DLY[gId[g]*W +: W] = W'(gDly[g]);
    end
    REQ = '0;
    waitUntil(lastDone + 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ack"}, int'(ACK), 0);
    checkOutput({tag, "_done"}, int'(DONE), 0);
    checkOutput({tag, "_busy"}, int'(BUSY), 0);
    checkOutput({tag, "_cur_id"}, int'(CUR_ID), 0);
    checkOutput({tag, "_cnt_en"}, int'(CNT_EN), 0);
    checkOutput({tag, "_cnt_load"}, int'(CNT_LOAD), 1);
    checkOutput({tag, "_cnt_data"}, int'(CNT_DATA), 0);
  endtask

  initial begin
    int t, mask, hold;
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkResetOutputs("reset");
    RST = 1'b1;
    @(posedge CLK);
    #1;

    setDly(0, 5);
    applyStimulus(4'b0001, 4'b0000, 1, 1'b0);
    setDly(1, 1);
    applyStimulus(4'b0010, 4'b0000, 1, 1'b0);
    setDly(1, 0);
    applyStimulus(4'b0010, 4'b0000, 1, 1'b0);
    for (int i = 0; i < NREQ; i++) setDly(i, 3);
    applyStimulus(4'b1111, 4'b1111, 5, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1, 1'b0);
    applyStimulus(4'b0011, 4'b0000, 4, 1'b0);
    setDly(2, 255);
    applyStimulus(4'b0100, 4'b0000, 1, 1'b0);

    // Reset in the middle of a D=10 run; the pointer must restart at 0.
    setDly(1, 10);
    setDly(3, 10);
    REQ = 4'b0010;
    t = cyc + 1;
    sb.push_back('{isDone: 1'b0, id: 1, cyc: t, dly: 10});
    waitUntil(t);
    REQ = '0;
    waitUntil(t + 2);
    RST = 1'b0;
    #1;
    checkResetOutputs("midjob");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    modelPtr = 0;
    @(posedge CLK);
    #1;
    applyStimulus(4'b1010, 4'b0000, 1, 1'b0);

`ifdef CNT_SCHED_ABORT_EN
    setDly(2, 10);
    REQ = 4'b0100;
    t = cyc + 1;
    sb.push_back('{isDone: 1'b0, id: 2, cyc: t, dly: 10});
    modelPtr = 3;
    waitUntil(t);
    REQ = '0;
    waitUntil(t + 3);
    ABORT = 4'b0100;
    #1;
    checkOutput("abort_en", int'(CNT_EN), 0);
    @(posedge CLK);
    #1;
    ABORT = '0;
    checkOutput("abort_busy", int'(BUSY), 0);
    repeat (14) @(posedge CLK);
    #1;
`endif

    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < NREQ; i++) setDly(i, randD());
      mask = int'($urandom_range(1, 15));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
      applyStimulus(NREQ'(mask), NREQ'(hold), int'($urandom_range(1, 6)), 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK);
        #1;
      end
    end

    repeat (20) @(posedge CLK);
    #1;
    checkOutput("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
